// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signal bundle for uart_tx_sched.
// The slave modport is the scheduler side; master is the surrounding logic.
`ifndef UART_LEN
`define UART_LEN 8
`endif

interface uart_tx_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*`UART_LEN-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      tx_we;
  logic [`UART_LEN-1:0]      tx_data;
  logic                      tx_busy;

  modport master (
    output req_valid,
    output req_data,
    output tx_busy,
    input  req_ready,
    input  tx_we,
    input  tx_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_busy,
    output req_ready,
    output tx_we,
    output tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler in front of a single UART transmitter:
// arbiter -> byte FIFO -> sequencer that watches tx_busy.
`ifndef UART_LEN
`define UART_LEN 8
`endif

module uart_tx_sched #(
  parameter  int NREQ      = 2,
  parameter  int DEPTH     = 4,
  parameter  int BUSY_WAIT = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int AW  = $clog2(DEPTH),
  localparam int LW  = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  uart_tx_sched_if.slave bus,
  output logic           done,
  output logic [IDW-1:0] done_id,
  output logic           err,
  output logic [LW-1:0]  level
);

  localparam int CW = $clog2(BUSY_WAIT + 1);
  localparam int BW = `UART_LEN;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0] rr_q, rr_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [LW-1:0]  level_q, level_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tx_we_q, tx_we_d;
  logic [BW-1:0]  tx_data_q, tx_data_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [BW-1:0]  dmem_q [DEPTH];
  logic [IDW-1:0] imem_q [DEPTH];

  logic           gnt_ok;
  logic [IDW-1:0] gnt_id;
  logic [NREQ-1:0] ready;
  logic [BW-1:0]  gnt_byte;
  logic           full;
  logic           push;
  logic           pop;

  assign full = (level_q == LW'(DEPTH));

  // rr_q holds the requester with top priority for the next grant
  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_q) + k) % NREQ]) begin
        gnt_ok = 1'b1;
        gnt_id = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n && gnt_ok && !full) begin
      ready[gnt_id] = 1'b1;
    end
  end

  assign push     = |(ready & bus.req_valid);
  assign gnt_byte = bus.req_data[int'(gnt_id)*BW +: BW];

  always_comb begin
    rr_d = rr_q;
    wr_d = wr_q;
    if (push) begin
      rr_d = IDW'((int'(gnt_id) + 1) % NREQ);
      wr_d = wr_q + AW'(1);
    end
  end

  always_comb begin
    rd_d    = rd_q;
    level_d = level_q;
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_we_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_id_d = done_id_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && level_q != '0 && !bus.tx_busy) begin
          pop       = 1'b1;
          tx_we_d   = 1'b1;
          tx_data_d = dmem_q[rd_q];
          done_id_d = imem_q[rd_q];
          cnt_d     = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (bus.tx_busy) begin
          state_d = SEND;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          // transmitter never responded: report and drop the byte
          cnt_d   = cnt_q + CW'(1);
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dmem_q[wr_q] <= gnt_byte;
      imem_q[wr_q] <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
      done_id_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
      done_id_q <= done_id_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_we     = tx_we_q;
  assign bus.tx_data   = tx_data_q;
  assign done          = done_q;
  assign done_id       = done_id_q;
  assign err           = err_q;
  assign level         = level_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single UART transmitter between NREQ byte requesters (e.g. core store path, debug/trace path).
- Round-robin arbiter feeds a DEPTH-entry byte FIFO; a sequencer FSM pops bytes into the transmitter and tracks its busy flag.
- Reports each completed byte with a one-cycle done pulse tagged with the source id, and flags transmitters that never go busy.
- Sits between the requesters and the transmitter instance, beside the memory-mapped UART register block.

Parameters:
NREQ, 2, number of requesters (1..8)
DEPTH, 4, FIFO entries, power of two (2..16)
BUSY_WAIT, 4, cycles allowed for tx_busy to rise after tx_we (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = sequencer may pop the FIFO; 0 = hold queued bytes
req_valid  input  NREQ  per-requester byte valid
req_data  input  NREQ*`UART_LEN  requester i byte at [i*`UART_LEN +: `UART_LEN]
req_ready  output  NREQ  one-hot accept; a transfer occurs on valid&ready
tx_we  output  1  one-cycle write strobe to transmitter
tx_data  output  `UART_LEN  byte to transmitter, stable from tx_we until the next pop
tx_busy  input  1  transmitter busy
done  output  1  one-cycle pulse: byte fully shifted out
done_id  output  max(1,clog2(NREQ))  source of the byte reported by done/err
err  output  1  one-cycle pulse: tx_busy did not rise within BUSY_WAIT
level  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n low): FIFO empty, level=0, rr pointer=0, FSM=IDLE, tx_we=0, tx_data=0, done=0, done_id=0, err=0, timeout counter=0; req_ready forced 0 while rst_n=0.
- Arbitration (combinational): if level<DEPTH, grant the first valid requester searching from (last_grant+1) mod NREQ upward with wrap; req_ready is the one-hot of that grant; otherwise req_ready=0.
- No push when full, even if a pop happens the same cycle. At most one push per cycle.
- On push: the entry {id, byte} is written at wr_ptr; last_grant <= granted id; wr_ptr wraps mod DEPTH.
- Simultaneous push and pop: level unchanged; both pointers advance.
- FSM IDLE: if enable & level!=0 & !tx_busy, pop the head; next cycle tx_we=1 and tx_data/done_id = head byte/id; go ARM, counter=0. Minimum latency from push to tx_we is 2 cycles (push edge, then pop edge).
- FSM ARM: each cycle with tx_busy=0, counter+1. If tx_busy=1, go SEND. If counter reaches BUSY_WAIT without busy, pulse err for 1 cycle (done_id = that byte's id), drop the byte, go IDLE.
- FSM SEND: wait for tx_busy=0; then pulse done for 1 cycle with done_id held, go IDLE. The next pop may occur in the same cycle done is high, if the IDLE conditions are met in that cycle.
- tx_we is high for exactly one cycle per popped byte; it is never asserted outside the IDLE->ARM transition.
- enable=0: in-flight ARM/SEND completes normally; no new pop; pushes continue until the FIFO is full.
- Reset mid-operation: all state is discarded immediately, queued bytes are lost, and no done or err pulse is issued for them.
- done and err are never high in the same cycle.

Test Plan:
- NREQ=2; req0 pushes 0x41 once; tx_busy rises 1 cycle after tx_we and falls 10 cycles later -> tx_we with tx_data=0x41 two cycles after the push; done=1 with done_id=0 one cycle after tx_busy falls; level returns to 0.
- req0 and req1 hold valid for 4 bytes each (0x10.., 0x20..) from reset -> accept order 0x10,0x20,0x11,0x21,...; transmitted bytes in that order; done_id alternates 0,1.
- tx_busy held 1, enable=1, req0 streams bytes -> exactly DEPTH=4 accepted; req_ready=0 with level=4; release busy -> ready returns after the first pop.
- tx_busy tied 0 -> err pulses exactly BUSY_WAIT=4 cycles after tx_we; done never asserts; the next queued byte issues tx_we afterwards.
- enable=0 with 3 bytes queued -> no tx_we, level=3; set enable=1 -> three transmissions in order.
- Assert rst_n=0 during SEND with 2 bytes queued -> outputs go to reset values asynchronously; after release level=0, no done or err, tx_we stays 0.
